multicycle_control_fsm: RTL and testbench

//  Main control FSM of the multicycle RISC-V datapath: the issuing side of the ALU_Op encoding.

---
 rtl/multicycle_control_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I-subset datapath (R/I-type ALU, LUI, LW, SW).
// Optional retired-instruction counter enabled by defining PERF_COUNT_EN.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic        i_or_d_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic        illegal_o,
`ifdef PERF_COUNT_EN
    output logic [31:0] instr_count_o,
`endif
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_EXEC_LUI = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_r;
    logic        illegal_r;
    logic        mem_state_s;
    logic        timeout_s;

    assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    assign timeout_s   = (wait_r == TIMEOUT_C) && !mem_ready_i;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory wait counter: runs while a memory state is stalled, zero otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_r <= 8'd0;
        end else if (mem_state_s && !mem_ready_i) begin
            wait_r <= wait_r + 8'd1;
        end else begin
            wait_r <= 8'd0;
        end
    end

    // Sticky trap flag
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else if (state_next_s == S_TRAP) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Next-state logic; ready in the timeout cycle still completes normally
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready_i)    state_next_s = S_DECODE;
                else if (timeout_s) state_next_s = S_TRAP;
                else                state_next_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_R:              state_next_s = S_EXEC_R;
                    OP_I:              state_next_s = S_EXEC_I;
                    OP_LUI:            state_next_s = S_EXEC_LUI;
                    OP_LOAD, OP_STORE: state_next_s = S_MEM_ADDR;
                    default:           state_next_s = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_next_s = S_WB_ALU;
            S_MEM_ADDR: begin
                if (opcode_i == OP_LOAD) state_next_s = S_MEM_RD;
                else                     state_next_s = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready_i)    state_next_s = S_WB_MEM;
                else if (timeout_s) state_next_s = S_TRAP;
                else                state_next_s = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready_i)    state_next_s = S_FETCH;
                else if (timeout_s) state_next_s = S_TRAP;
                else                state_next_s = S_MEM_WR;
            end
            S_WB_ALU, S_WB_MEM: state_next_s = S_FETCH;
            default:            state_next_s = S_TRAP;
        endcase
    end

    // Output decode from state; everything held low while reset is asserted
    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        i_or_d_o     = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        illegal_o    = 1'b0;
        state_o      = 4'd0;
        if (reset) begin
            state_o = 4'd0;
        end else begin
            state_o   = state_r;
            illegal_o = illegal_r;
            case (state_r)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'b01;
                    alu_op_o    = 3'b011;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_EXEC_R: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b00;
                    alu_op_o    = 3'b000;
                end
                S_EXEC_I: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = 3'b001;
                end
                S_EXEC_LUI: begin
                    alu_src_b_o = 2'b10;
                    alu_op_o    = 3'b010;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = 3'b011;
                end
                S_MEM_RD: begin
                    mem_req_o = 1'b1;
                    i_or_d_o  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req_o   = 1'b1;
                    mem_write_o = 1'b1;
                    i_or_d_o    = 1'b1;
                end
                S_WB_ALU: reg_write_o = 1'b1;
                S_WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                default: alu_op_o = 3'b000;
            endcase
        end
    end

`ifdef PERF_COUNT_EN
    logic [31:0] count_r;
    logic        retire_s;

    assign retire_s = (state_r == S_WB_ALU) || (state_r == S_WB_MEM) ||
                      ((state_r == S_MEM_WR) && mem_ready_i);

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 32'd0;
        end else if (retire_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign instr_count_o = reset ? 32'd0 : count_r;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [3:0] ST_F   = 4'd0;
    localparam logic [3:0] ST_D   = 4'd1;
    localparam logic [3:0] ST_XR  = 4'd2;
    localparam logic [3:0] ST_XI  = 4'd3;
    localparam logic [3:0] ST_XU  = 4'd4;
    localparam logic [3:0] ST_MA  = 4'd5;
    localparam logic [3:0] ST_MR  = 4'd6;
    localparam logic [3:0] ST_MW  = 4'd7;
    localparam logic [3:0] ST_WA  = 4'd8;
    localparam logic [3:0] ST_WM  = 4'd9;
    localparam logic [3:0] ST_T   = 4'd15;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode_i;
    logic        mem_ready_i;
    logic        mem_req_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o;
    logic        reg_write_o, mem_to_reg_o, illegal_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic [3:0]  state_o;
`ifdef PERF_COUNT_EN
    logic [31:0] instr_count_o;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, mem_to_reg;
        logic [1:0] src_a, src_b;
        logic [2:0] alu_op;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        outs_t       o;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    outs_t       act;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cnt_e = 32'd0;

    multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .i_or_d_o(i_or_d_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .illegal_o(illegal_o),
`ifdef PERF_COUNT_EN
        .instr_count_o(instr_count_o),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign act = {state_o, mem_req_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
                  reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o};

    // Output table for each state, written from the state descriptions
    function automatic outs_t spec_out(input logic [3:0] st, input logic rdy, input logic rst);
        outs_t o;
        o = '0;
        if (!rst) begin
            o.st = st;
            case (st)
                ST_F:  begin o.mem_req = 1'b1; o.src_b = 2'b01; o.alu_op = 3'b011;
                             o.ir_write = rdy; o.pc_write = rdy; end
                ST_XR: begin o.src_a = 2'b01; o.src_b = 2'b00; o.alu_op = 3'b000; end
                ST_XI: begin o.src_a = 2'b01; o.src_b = 2'b10; o.alu_op = 3'b001; end
                ST_XU: begin o.src_b = 2'b10; o.alu_op = 3'b010; end
                ST_MA: begin o.src_a = 2'b01; o.src_b = 2'b10; o.alu_op = 3'b011; end
                ST_MR: begin o.mem_req = 1'b1; o.i_or_d = 1'b1; end
                ST_MW: begin o.mem_req = 1'b1; o.mem_write = 1'b1; o.i_or_d = 1'b1; end
                ST_WA: o.reg_write = 1'b1;
                ST_WM: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
                ST_T:  o.illegal = 1'b1;
                default: o.st = st;
            endcase
        end
        return o;
    endfunction

    task automatic step(input logic [3:0] st, input logic rdy, input logic [6:0] opc,
                        input logic rst = 1'b0);
        exp_t e;
        reset       = rst;
        mem_ready_i = rdy;
        opcode_i    = opc;
        e.o   = spec_out(st, rdy, rst);
        e.cnt = rst ? 32'd0 : cnt_e;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_vec++;
            if (act !== mon_e.o) begin
                n_err++;
                $display("FAIL vec%0d outputs: got %h (state %0d) expected %h (state %0d)",
                         n_vec, act, act.st, mon_e.o, mon_e.o.st);
            end
`ifdef PERF_COUNT_EN
            n_vec++;
            if (instr_count_o !== mon_e.cnt) begin
                n_err++;
                $display("FAIL vec%0d instr_count: got %0d expected %0d",
                         n_vec, instr_count_o, mon_e.cnt);
            end
`endif
        end
    end

    initial begin
        reset       = 1'b1;
        mem_ready_i = 1'b0;
        opcode_i    = OP_R;
        @(posedge clk);
        #1;
        step(ST_F, 1'b0, OP_R, 1'b1);
        step(ST_F, 1'b0, OP_R, 1'b1);
        cnt_e = 32'd0;

        // R-type, no memory stall
        step(ST_F, 1'b1, OP_R); step(ST_D, 1'b0, OP_R); step(ST_XR, 1'b0, OP_R); step(ST_WA, 1'b0, OP_R);
        cnt_e = cnt_e + 32'd1;

        // LW with three stall cycles in MEM_RD
        step(ST_F, 1'b1, OP_LW); step(ST_D, 1'b0, OP_LW); step(ST_MA, 1'b0, OP_LW);
        repeat (3) step(ST_MR, 1'b0, OP_LW);
        step(ST_MR, 1'b1, OP_LW); step(ST_WM, 1'b0, OP_LW);
        cnt_e = cnt_e + 32'd1;

        // I-type and LUI
        step(ST_F, 1'b1, OP_I); step(ST_D, 1'b0, OP_I); step(ST_XI, 1'b0, OP_I); step(ST_WA, 1'b0, OP_I);
        cnt_e = cnt_e + 32'd1;
        step(ST_F, 1'b1, OP_LUI); step(ST_D, 1'b0, OP_LUI); step(ST_XU, 1'b0, OP_LUI); step(ST_WA, 1'b0, OP_LUI);
        cnt_e = cnt_e + 32'd1;

        // SW with fetch stalls and one write stall
        step(ST_F, 1'b0, OP_SW); step(ST_F, 1'b0, OP_SW); step(ST_F, 1'b1, OP_SW);
        step(ST_D, 1'b0, OP_SW); step(ST_MA, 1'b0, OP_SW);
        step(ST_MW, 1'b0, OP_SW); step(ST_MW, 1'b1, OP_SW);
        cnt_e = cnt_e + 32'd1;

        // Ready arriving exactly at counter==4 still completes the fetch
        repeat (4) step(ST_F, 1'b0, OP_R);
        step(ST_F, 1'b1, OP_R); step(ST_D, 1'b0, OP_R); step(ST_XR, 1'b0, OP_R); step(ST_WA, 1'b0, OP_R);
        cnt_e = cnt_e + 32'd1;

        // Fetch timeout: five waiting cycles then TRAP, count frozen
        repeat (5) step(ST_F, 1'b0, OP_R);
        repeat (3) step(ST_T, 1'b1, OP_R);
        step(ST_F, 1'b0, OP_R, 1'b1);
        cnt_e = 32'd0;

        // Illegal opcode: TRAP held 20 cycles
        step(ST_F, 1'b1, OP_BAD); step(ST_D, 1'b0, OP_BAD);
        for (int i = 0; i < 20; i++) step(ST_T, 1'(i), OP_BAD);
        step(ST_F, 1'b0, OP_BAD, 1'b1);
        cnt_e = 32'd0;
        step(ST_F, 1'b0, OP_R);

        // R, LUI, SW back to back, then reset during EXEC
        step(ST_F, 1'b1, OP_R); step(ST_D, 1'b0, OP_R); step(ST_XR, 1'b0, OP_R); step(ST_WA, 1'b0, OP_R);
        cnt_e = cnt_e + 32'd1;
        step(ST_F, 1'b1, OP_LUI); step(ST_D, 1'b0, OP_LUI); step(ST_XU, 1'b0, OP_LUI); step(ST_WA, 1'b0, OP_LUI);
        cnt_e = cnt_e + 32'd1;
        step(ST_F, 1'b1, OP_SW); step(ST_D, 1'b0, OP_SW); step(ST_MA, 1'b0, OP_SW); step(ST_MW, 1'b1, OP_SW);
        cnt_e = cnt_e + 32'd1;
        step(ST_F, 1'b1, OP_R); step(ST_D, 1'b0, OP_R);
        step(ST_XR, 1'b0, OP_R, 1'b1);
        cnt_e = 32'd0;
        step(ST_F, 1'b0, OP_R);

        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
